// File: rtl/cart_header_capture_if.sv
// ROM download byte stream as seen by the header snooper.
// The loader drives it as master; cart_header_capture listens as slave.
interface cart_header_capture_if #(
    parameter int ADDR_W = 23
) ();
    logic              dl_active;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;

    modport master (output dl_active, output dl_wr, output dl_addr, output dl_data);
    modport slave  (input  dl_active, input  dl_wr, input  dl_addr, input  dl_data);
endinterface

// File: rtl/cart_header_capture.sv
// Snoops the ROM download, captures header fields, checks checksum/length and (CART_MBC1M_DETECT_EN) MBC1M logo.
// Latency: results published with a hdr_valid pulse one cycle after the first clk_sys edge that samples dl_active low.
// Backpressure: none; a pure listener that accepts every write of the download stream.
module cart_header_capture #(
    parameter int ADDR_W = 23
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    cart_header_capture_if.slave  dl,
    output logic [7:0]            cart_cgb_flag,
    output logic [7:0]            cart_sgb_flag,
    output logic [7:0]            cart_mbc_type,
    output logic [7:0]            cart_rom_size,
    output logic [7:0]            cart_ram_size,
    output logic [7:0]            cart_old_licensee,
    output logic                  mbc1m,
    output logic                  hdr_chk_ok,
    output logic                  rom_size_ok,
    output logic                  hdr_valid
);
    localparam logic [ADDR_W-1:0] A_CGB     = ADDR_W'(20'h00143);
    localparam logic [ADDR_W-1:0] A_SGB     = ADDR_W'(20'h00146);
    localparam logic [ADDR_W-1:0] A_MBC     = ADDR_W'(20'h00147);
    localparam logic [ADDR_W-1:0] A_ROM     = ADDR_W'(20'h00148);
    localparam logic [ADDR_W-1:0] A_RAM     = ADDR_W'(20'h00149);
    localparam logic [ADDR_W-1:0] A_LIC     = ADDR_W'(20'h0014B);
    localparam logic [ADDR_W-1:0] A_CHK_LO  = ADDR_W'(20'h00134);
    localparam logic [ADDR_W-1:0] A_CHK_HI  = ADDR_W'(20'h0014C);
    localparam logic [ADDR_W-1:0] A_CHK_REF = ADDR_W'(20'h0014D);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PUBLISH} state_t;

    state_t            state, state_nxt;
    logic              act_q;
    logic              rise, fall;
    logic              clr, accept, publish;
    logic [7:0]        sh_cgb, sh_sgb, sh_mbc, sh_rom, sh_ram, sh_lic;
    logic [7:0]        chk, chk_ref;
    logic [ADDR_W-1:0] max_addr;
    logic [ADDR_W:0]   declared;
    logic              size_known;
    logic              size_ok_d;
    logic              mbc1m_d;

    assign rise = dl.dl_active & ~act_q;
    assign fall = ~dl.dl_active & act_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            act_q <= 1'b0;
        end else begin
            state <= state_nxt;
            act_q <= dl.dl_active;
        end
    end

    // A new download always restarts capture, even over a pending publish.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = S_IDLE;
            S_LOAD:    if (fall) state_nxt = S_PUBLISH;
            S_PUBLISH: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (rise) state_nxt = S_LOAD;
    end

    always_comb begin
        clr     = rise;
        accept  = (state == S_LOAD) & dl.dl_active & dl.dl_wr;
        publish = (state == S_PUBLISH) & ~rise;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            {sh_cgb, sh_sgb, sh_mbc, sh_rom, sh_ram, sh_lic} <= '0;
            chk      <= '0;
            chk_ref  <= '0;
            max_addr <= '0;
        end else if (clr) begin
            {sh_cgb, sh_sgb, sh_mbc, sh_rom, sh_ram, sh_lic} <= '0;
            chk      <= '0;
            chk_ref  <= '0;
            max_addr <= '0;
        end else if (accept) begin
            if (dl.dl_addr == A_CGB) sh_cgb <= dl.dl_data;
            if (dl.dl_addr == A_SGB) sh_sgb <= dl.dl_data;
            if (dl.dl_addr == A_MBC) sh_mbc <= dl.dl_data;
            if (dl.dl_addr == A_ROM) sh_rom <= dl.dl_data;
            if (dl.dl_addr == A_RAM) sh_ram <= dl.dl_data;
            if (dl.dl_addr == A_LIC) sh_lic <= dl.dl_data;
            if (dl.dl_addr >= A_CHK_LO && dl.dl_addr <= A_CHK_HI)
                chk <= chk - dl.dl_data - 8'd1;
            if (dl.dl_addr == A_CHK_REF) chk_ref <= dl.dl_data;
            if (dl.dl_addr > max_addr) max_addr <= dl.dl_addr;
        end
    end

`ifdef CART_MBC1M_DETECT_EN
    localparam logic [ADDR_W-1:0] A_LOGO_LO = ADDR_W'(20'h00104);
    localparam logic [ADDR_W-1:0] A_LOGO_HI = ADDR_W'(20'h00133);
    localparam logic [ADDR_W-1:0] A_CMP_LO  = ADDR_W'(20'h40104);
    localparam logic [ADDR_W-1:0] A_CMP_HI  = ADDR_W'(20'h40133);

    logic [7:0] logo_buf [48];
    logic       logo_seen, logo_miss;
    logic [5:0] logo_cnt;
    logic [5:0] st_idx, cmp_idx;
    logic       logo_st, logo_cmp;

    assign st_idx   = 6'(dl.dl_addr - A_LOGO_LO);
    assign cmp_idx  = 6'(dl.dl_addr - A_CMP_LO);
    assign logo_st  = accept && dl.dl_addr >= A_LOGO_LO && dl.dl_addr <= A_LOGO_HI;
    assign logo_cmp = accept && dl.dl_addr >= A_CMP_LO && dl.dl_addr <= A_CMP_HI;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 48; i++) logo_buf[i] <= '0;
            logo_seen <= 1'b0;
            logo_miss <= 1'b0;
            logo_cnt  <= '0;
        end else if (clr) begin
            for (int i = 0; i < 48; i++) logo_buf[i] <= '0;
            logo_seen <= 1'b0;
            logo_miss <= 1'b0;
            logo_cnt  <= '0;
        end else begin
            if (logo_st) begin
                logo_buf[st_idx] <= dl.dl_data;
                logo_seen        <= 1'b1;
            end
            if (logo_cmp) begin
                if (logo_buf[cmp_idx] != dl.dl_data) logo_miss <= 1'b1;
                if (logo_cnt != 6'd48) logo_cnt <= logo_cnt + 6'd1;
            end
        end
    end

    assign mbc1m_d = logo_seen & (logo_cnt == 6'd48) & ~logo_miss;
`else
    assign mbc1m_d = 1'b0;
`endif

    // Declared image length; computed one bit wider than the address so 8 MB fits.
    always_comb begin
        declared   = '0;
        size_known = 1'b0;
        if (sh_rom <= 8'h08) begin
            declared   = (ADDR_W+1)'(32'h8000) << sh_rom[3:0];
            size_known = 1'b1;
        end else begin
            case (sh_rom)
                8'h52:   begin declared = (ADDR_W+1)'(32'h120000); size_known = 1'b1; end
                8'h53:   begin declared = (ADDR_W+1)'(32'h140000); size_known = 1'b1; end
                8'h54:   begin declared = (ADDR_W+1)'(32'h180000); size_known = 1'b1; end
                default: begin declared = '0; size_known = 1'b0; end
            endcase
        end
        size_ok_d = size_known & (({1'b0, max_addr} + (ADDR_W+1)'(1)) >= declared);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            {cart_cgb_flag, cart_sgb_flag, cart_mbc_type} <= '0;
            {cart_rom_size, cart_ram_size, cart_old_licensee} <= '0;
            {mbc1m, hdr_chk_ok, rom_size_ok, hdr_valid} <= '0;
        end else if (clr) begin
            {cart_cgb_flag, cart_sgb_flag, cart_mbc_type} <= '0;
            {cart_rom_size, cart_ram_size, cart_old_licensee} <= '0;
            {mbc1m, hdr_chk_ok, rom_size_ok, hdr_valid} <= '0;
        end else if (publish) begin
            cart_cgb_flag     <= sh_cgb;
            cart_sgb_flag     <= sh_sgb;
            cart_mbc_type     <= sh_mbc;
            cart_rom_size     <= sh_rom;
            cart_ram_size     <= sh_ram;
            cart_old_licensee <= sh_lic;
            mbc1m             <= mbc1m_d;
            hdr_chk_ok        <= (chk == chk_ref);
            rom_size_ok       <= size_ok_d;
            hdr_valid         <= 1'b1;
        end else begin
            hdr_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cart_header_capture.sv
// Scoreboard bench for cart_header_capture: each download pushes its expected header record,
// the monitor pops and compares it on every hdr_valid pulse.
module tb_cart_header_capture;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    cart_header_capture_if #(.ADDR_W(23)) dl_if ();

    logic [7:0] cart_cgb_flag, cart_sgb_flag, cart_mbc_type;
    logic [7:0] cart_rom_size, cart_ram_size, cart_old_licensee;
    logic       mbc1m, hdr_chk_ok, rom_size_ok, hdr_valid;

    cart_header_capture #(.ADDR_W(23)) dut (
        .clk_sys           (clk_sys),
        .reset_n           (reset_n),
        .dl                (dl_if),
        .cart_cgb_flag     (cart_cgb_flag),
        .cart_sgb_flag     (cart_sgb_flag),
        .cart_mbc_type     (cart_mbc_type),
        .cart_rom_size     (cart_rom_size),
        .cart_ram_size     (cart_ram_size),
        .cart_old_licensee (cart_old_licensee),
        .mbc1m             (mbc1m),
        .hdr_chk_ok        (hdr_chk_ok),
        .rom_size_ok       (rom_size_ok),
        .hdr_valid         (hdr_valid)
    );

`ifdef CART_MBC1M_DETECT_EN
    localparam logic MBC_EN = 1'b1;
`else
    localparam logic MBC_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] cgb, sgb, mbc, rom, ram, lic;
        logic       m1, chk, sz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk_sys) begin
        exp_t e;
        if (reset_n === 1'b1 && hdr_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("unexpected_hdr_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_val("cgb_flag",     64'(cart_cgb_flag),     64'(e.cgb));
                check_val("sgb_flag",     64'(cart_sgb_flag),     64'(e.sgb));
                check_val("mbc_type",     64'(cart_mbc_type),     64'(e.mbc));
                check_val("rom_size",     64'(cart_rom_size),     64'(e.rom));
                check_val("ram_size",     64'(cart_ram_size),     64'(e.ram));
                check_val("old_licensee", 64'(cart_old_licensee), 64'(e.lic));
                check_val("mbc1m",        64'(mbc1m),             64'(e.m1));
                check_val("hdr_chk_ok",   64'(hdr_chk_ok),        64'(e.chk));
                check_val("rom_size_ok",  64'(rom_size_ok),       64'(e.sz));
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] mbc, input logic [7:0] rom, input logic [7:0] ram,
                            input logic m1, input logic chk, input logic sz);
        exp_t e;
        e.cgb = 8'h80; e.sgb = 8'h03; e.lic = 8'h33;
        e.mbc = mbc;   e.rom = rom;   e.ram = ram;
        e.m1  = m1;    e.chk = chk;   e.sz  = sz;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({cart_cgb_flag, cart_sgb_flag, cart_mbc_type, cart_rom_size, cart_ram_size,
                    cart_old_licensee, mbc1m, hdr_chk_ok, rom_size_ok, hdr_valid});
    endfunction

    task automatic wr(input logic [22:0] a, input logic [7:0] d);
        dl_if.dl_wr   = 1'b1;
        dl_if.dl_addr = a;
        dl_if.dl_data = d;
        step();
        dl_if.dl_wr   = 1'b0;
    endtask

    task automatic begin_dl();
        dl_if.dl_active = 1'b1;
        dl_if.dl_wr     = 1'b0;
        step();
    endtask

    // Header 0x134..0x14D; checksum byte is correct when good=1, inverted otherwise.
    task automatic send_header(input logic [7:0] mbc, input logic [7:0] rom, input logic [7:0] ram,
                               input logic good, input logic desc);
        logic [7:0]  h [26];
        logic [7:0]  c;
        logic [22:0] a;
        c = 8'h00;
        for (int i = 0; i < 26; i++) begin
            a    = 23'(32'h134 + i);
            h[i] = a[7:0] ^ 8'h5A;
        end
        h[15] = 8'h80; h[18] = 8'h03; h[19] = mbc;
        h[20] = rom;   h[21] = ram;   h[23] = 8'h33;
        for (int i = 0; i < 25; i++) c = c - h[i] - 8'd1;
        h[25] = good ? c : ~c;
        if (desc) for (int i = 25; i >= 0; i--) wr(23'(32'h134 + i), h[i]);
        else      for (int i = 0; i < 26; i++)  wr(23'(32'h134 + i), h[i]);
    endtask

    task automatic send_logo(input logic [22:0] base, input logic corrupt);
        logic [7:0] b;
        for (int i = 0; i < 48; i++) begin
            b = 8'(i * 5 + 32'hCE);
            if (corrupt && i == 28) b = b ^ 8'hFF;
            wr(23'(32'(base) + i), b);
        end
    endtask

    // Drop dl_active; optionally keep writing garbage that must be ignored.
    task automatic end_dl(input logic garbage);
        dl_if.dl_active = 1'b0;
        if (garbage) begin
            dl_if.dl_wr   = 1'b1;
            dl_if.dl_addr = 23'h14D;
            dl_if.dl_data = 8'hEE;
        end
        step();
        check_val("hv_publish_cycle", 64'(hdr_valid), 64'd0);
        dl_if.dl_addr = 23'h147;
        step();
        check_val("hv_pulse", 64'(hdr_valid), 64'd1);
        dl_if.dl_wr = 1'b0;
        step();
        check_val("hv_one_cycle", 64'(hdr_valid), 64'd0);
    endtask

    initial begin
        dl_if.dl_active = 1'b0;
        dl_if.dl_wr     = 1'b0;
        dl_if.dl_addr   = '0;
        dl_if.dl_data   = '0;
        #12;
        check_val("reset_outputs", all_outs(), 64'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        step();

        // Valid 256 KB MBC1 image, header in order, last byte at 0x3FFFF
        begin_dl();
        send_header(8'h03, 8'h03, 8'h02, 1'b1, 1'b0);
        wr(23'h3FFFF, 8'h11);
        push_exp(8'h03, 8'h03, 8'h02, 1'b0, 1'b1, 1'b1);
        end_dl(1'b0);

        // Stray writes while idle, then descending header ending in the last high cycle
        dl_if.dl_addr = 23'h147; dl_if.dl_data = 8'h77; dl_if.dl_wr = 1'b1;
        step(); step();
        dl_if.dl_wr = 1'b0;
        begin_dl();
        send_header(8'h01, 8'h00, 8'h00, 1'b1, 1'b1);
        push_exp(8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        end_dl(1'b1);

        // Corrupted checksum, image truncated at 128 KB for a 256 KB declaration
        begin_dl();
        send_header(8'h03, 8'h03, 8'h02, 1'b0, 1'b0);
        wr(23'h1FFFF, 8'h22);
        push_exp(8'h03, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        end_dl(1'b0);

        // MBC1M: 1 MB image with the logo copied at 0x40104, then with 0x40120 altered
        for (int k = 0; k < 2; k++) begin
            begin_dl();
            send_logo(23'h104, 1'b0);
            send_header(8'h01, 8'h05, 8'h00, 1'b1, 1'b0);
            send_logo(23'h40104, k == 1);
            wr(23'hFFFFF, 8'h33);
            push_exp(8'h01, 8'h05, 8'h00, (k == 0) ? MBC_EN : 1'b0, 1'b1, 1'b1);
            end_dl(1'b0);
        end

        // Size code boundaries: 0x52 exact, 0x54 one short, 0x09 unknown, 0x08 full 8 MB
        begin_dl(); send_header(8'h19, 8'h52, 8'h01, 1'b1, 1'b0); wr(23'h11FFFF, 8'h01);
        push_exp(8'h19, 8'h52, 8'h01, 1'b0, 1'b1, 1'b1); end_dl(1'b0);
        begin_dl(); send_header(8'h19, 8'h54, 8'h01, 1'b1, 1'b0); wr(23'h17FFFE, 8'h01);
        push_exp(8'h19, 8'h54, 8'h01, 1'b0, 1'b1, 1'b0); end_dl(1'b0);
        begin_dl(); send_header(8'h19, 8'h09, 8'h01, 1'b1, 1'b0); wr(23'h7FFFFF, 8'h01);
        push_exp(8'h19, 8'h09, 8'h01, 1'b0, 1'b1, 1'b0); end_dl(1'b0);
        begin_dl(); send_header(8'h1A, 8'h08, 8'h04, 1'b1, 1'b0); wr(23'h7FFFFF, 8'h01);
        push_exp(8'h1A, 8'h08, 8'h04, 1'b0, 1'b1, 1'b1); end_dl(1'b0);

        // Restart in the PUBLISH cycle: no pulse, outputs cleared, next load publishes
        begin_dl();
        send_header(8'h13, 8'h02, 8'h03, 1'b1, 1'b0);
        wr(23'h1FFFF, 8'h44);
        dl_if.dl_active = 1'b0;
        step();
        dl_if.dl_active = 1'b1;
        step();
        check_val("restart_no_valid", 64'(hdr_valid), 64'd0);
        check_val("restart_outs_clr", all_outs(), 64'd0);
        send_header(8'h1B, 8'h00, 8'h03, 1'b1, 1'b0);
        wr(23'h7FFF, 8'h55);
        push_exp(8'h1B, 8'h00, 8'h03, 1'b0, 1'b1, 1'b1);
        end_dl(1'b0);

        // Asynchronous reset mid-LOAD, released with dl_active still high
        begin_dl();
        send_header(8'h05, 8'h04, 8'h00, 1'b1, 1'b0);
        #3 reset_n = 1'b0;
        #1 check_val("midload_reset_outs", all_outs(), 64'd0);
        step();
        check_val("reset_no_valid", 64'(hdr_valid), 64'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        step();
        send_header(8'h06, 8'h00, 8'h00, 1'b1, 1'b0);
        wr(23'h7FFF, 8'h66);
        push_exp(8'h06, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        end_dl(1'b0);

        repeat (3) step();
        check_val("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cart_header_capture.md
# cart_header_capture

Upstream stage of the memory bank controller: snoops the cartridge ROM download stream while the ROM image is written into SDRAM. It captures the header bytes the controller consumes (`cart_mbc_type`, `cart_rom_size`, `cart_ram_size`), verifies the header checksum and ROM length, and detects MBC1M multicarts by logo comparison. All results are published together in one cycle when the download ends.

## Interface
Parameters:
- `ADDR_W`, 23: download byte-address width, covering 8 MB.

Ports:
- `clk_sys`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `dl_active`  in  1: ROM download in progress.
- `dl_wr`  in  1: one ROM byte is written this cycle.
- `dl_addr`  in  ADDR_W: byte address inside the ROM image.
- `dl_data`  in  8: byte being written.
- `cart_cgb_flag`  out  8: header byte 0x143.
- `cart_sgb_flag`  out  8: header byte 0x146.
- `cart_mbc_type`  out  8: header byte 0x147.
- `cart_rom_size`  out  8: header byte 0x148.
- `cart_ram_size`  out  8: header byte 0x149.
- `cart_old_licensee`  out  8: header byte 0x14B.
- `mbc1m`  out  1: MBC1M multicart detected.
- `hdr_chk_ok`  out  1: computed header checksum equals byte 0x14D.
- `rom_size_ok`  out  1: the image length covers the size declared in 0x148.
- `hdr_valid`  out  1: one-cycle pulse when the outputs above are updated.

## Operation
The block is a three-state machine: IDLE, LOAD, PUBLISH.

Download edges:
- `dl_active` is registered internally (`act_q`, reset 0).
- A rising edge (`dl_active & ~act_q`) from any state clears every capture register and moves the machine to LOAD.
- Because `act_q` resets to 0, a high `dl_active` right after reset counts as a rising edge and starts a fresh LOAD.

In LOAD, each cycle with `dl_active & dl_wr` is accepted. Writes while `dl_active` is low are ignored. Per accepted byte:
- **Header fields:** an address match on 0x143, 0x146, 0x147, 0x148, 0x149 or 0x14B stores the byte into the matching shadow register.
- **Checksum:** for addresses 0x134–0x14C, `chk <= chk - dl_data - 1`, modulo 256, with `chk` starting at 0. The rule does not depend on write order. A byte at 0x14D is stored as `chk_ref`.
- **ROM length:** `max_addr` tracks the largest accepted address.
- **Logo store:** bytes at 0x104–0x133 are written into a 48×8 logo buffer, indexed by `addr - 0x104`, and `logo_seen` is set.
- **Logo compare:** bytes at 0x40104–0x40133 are compared with the buffer entry at the same index. Any mismatch sets sticky `logo_miss`. Each compared byte increments the 6-bit counter `logo_cnt`, which saturates at 48.

A falling edge of `dl_active` in LOAD moves to PUBLISH. A write accepted in the last high cycle is still counted. PUBLISH lasts one cycle and then returns to IDLE. In PUBLISH:
- The six header outputs load from the shadow registers.
- `hdr_chk_ok = (chk == chk_ref)`.
- `mbc1m = logo_seen & (logo_cnt == 48) & ~logo_miss`.
- `rom_size_ok`: the declared length is 0x8000 << `cart_rom_size` when `cart_rom_size` ≤ 8. Codes 0x52, 0x53 and 0x54 declare 72, 80 and 96 banks of 16 KB. `rom_size_ok = (max_addr + 1 >= declared)`, computed at ADDR_W+1 bits so it cannot overflow. Any other code gives 0.
- `hdr_valid` = 1.

Outputs:
- A rising edge drives all outputs to 0 for the duration of LOAD.
- Outputs hold their values through IDLE.

## Timing
- Reset value: every output and every internal register is 0, and the state is IDLE.
- Captures and checksum update take 1 cycle. Output values are not visible until PUBLISH.
- `hdr_valid` goes high exactly one cycle after the first `clk_sys` edge that samples `dl_active` low, and stays high for 1 cycle.
- The new outputs appear in the same cycle as the `hdr_valid` pulse.
- A rising edge that coincides with PUBLISH wins: the machine clears and enters LOAD, and `hdr_valid` stays low.
- Reset mid-download: everything is cleared asynchronously. The partial image is not published.

## Configuration
- `CART_MBC1M_DETECT_EN` defined: the logo buffer, the compare logic and `logo_cnt` are built as described above.
- `CART_MBC1M_DETECT_EN` undefined: none of that logic is built, and `mbc1m` is tied to 0. All other behaviour is unchanged.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-LOAD → all outputs 0, no `hdr_valid`. Then release with `dl_active` high → a new LOAD begins.
- **Valid 256 KB MBC1 image:** stream 0x40000 bytes in order with 0x147=0x03, 0x148=0x03, 0x149=0x02 and a correct 0x14D → one `hdr_valid` pulse, `cart_mbc_type`=0x03, `hdr_chk_ok`=1, `rom_size_ok`=1, `mbc1m`=0.
- **Corrupted checksum, truncated image:** flip 0x14D and stop the image at 0x20000 bytes with 0x148=0x03 → `hdr_chk_ok`=0, `rom_size_ok`=0.
- **MBC1M:** a 1 MB image whose logo at 0x40104 copies the logo at 0x104 → `mbc1m`=1. Change the byte at 0x40120 → `mbc1m`=0. Build without `CART_MBC1M_DETECT_EN` → `mbc1m`=0 in both cases.
- **Out-of-order header writes:** send bytes 0x14D down to 0x134 with a write in the last high cycle of `dl_active` → `hdr_chk_ok`=1 and that last byte is counted. `dl_wr` pulses while `dl_active`=0 are ignored.
- **Restart in PUBLISH:** raise `dl_active` again in the PUBLISH cycle → no `hdr_valid`, outputs cleared to 0, state LOAD.
